// File: rtl/a_b_and_alu_pkg.sv
// Shared definitions for the A/B operand and ALU datapath slice.
// Contents: datapath width, A-mux constant, ALU operation codes and the
// A-mux / B-mux select encodings used by the top level and the ALU.
package a_b_and_alu_pkg;

    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] CONST_A7_DEFAULT = 16'h00F0;

    typedef enum logic [2:0] {
        ALU_AND   = 3'd0,
        ALU_OR    = 3'd1,
        ALU_NOR   = 3'd2,
        ALU_ADD   = 3'd3,
        ALU_SUB   = 3'd4,
        ALU_SLT   = 3'd5,
        ALU_XOR   = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ASEL_PC    = 3'd0,
        ASEL_AREG  = 3'd1,
        ASEL_ZERO  = 3'd2,
        ASEL_READ1 = 3'd3,
        ASEL_C     = 3'd4,
        ASEL_EXT   = 3'd5,
        ASEL_ONE   = 3'd6,
        ASEL_CONST = 3'd7
    } asel_e;

    typedef enum logic [1:0] {
        BSEL_BREG  = 2'd0,
        BSEL_EXT   = 2'd1,
        BSEL_SHIFT = 2'd2,
        BSEL_ONE   = 2'd3
    } bsel_e;

endpackage

// File: rtl/a_b_and_alu_if.sv
// Operand/control/result bundle for the A/B/ALU datapath slice.
// master: the controller/register-file side driving operands and controls.
// slave: the datapath slice, returning ALUOut, ALUOutReg, Zero and OverFlow.
interface a_b_and_alu_if;
    import a_b_and_alu_pkg::*;

    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Read1;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] ExType;
    logic [WIDTH-1:0] Shifter;
    logic             AWrite;
    logic             BWrite;
    logic             ALUOutWrite;
    logic [2:0]       ALUAinput;
    logic [1:0]       ALUBinput;
    logic [2:0]       ALUOp;
    logic [WIDTH-1:0] ALUOut;
    logic [WIDTH-1:0] ALUOutReg;
    logic             Zero;
    logic             OverFlow;

    modport master (
        output PC, A, B, Read1, C, ExType, Shifter,
        output AWrite, BWrite, ALUOutWrite, ALUAinput, ALUBinput, ALUOp,
        input  ALUOut, ALUOutReg, Zero, OverFlow
    );

    modport slave (
        input  PC, A, B, Read1, C, ExType, Shifter,
        input  AWrite, BWrite, ALUOutWrite, ALUAinput, ALUBinput, ALUOp,
        output ALUOut, ALUOutReg, Zero, OverFlow
    );

endinterface

// File: rtl/a_b_and_alu_alu16.sv
// 16-bit ALU: AND/OR/NOR/ADD/SUB/SLT/XOR/pass-Y with zero and signed-overflow flags.
// Latency: purely combinational.
// Ports: x, y operands; op operation code; result, zero, overflow outputs.
module alu16
    import a_b_and_alu_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;

    // Carry-out is intentionally dropped: arithmetic wraps modulo 2^WIDTH.
    assign sum  = x + y;
    assign diff = x - y;
    // Direct signed compare, so SLT stays correct even when x-y overflows.
    assign slt  = ($signed(x) < $signed(y));

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_op_e'(op))
            ALU_AND:   result = x & y;
            ALU_OR:    result = x | y;
            ALU_NOR:   result = ~(x | y);
            ALU_ADD: begin
                result   = sum;
                overflow = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
            end
            ALU_SLT:   result = {{(WIDTH-1){1'b0}}, slt};
            ALU_XOR:   result = x ^ y;
            ALU_PASSB: result = y;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/a_b_and_alu.sv
// Operand latch + ALU slice: A/B operand registers, 8:1 A-mux, 4:1 B-mux, ALU, ALUOutReg.
// Latency: ALUOut/Zero/OverFlow combinational; ALUOutReg one cycle after ALUOutWrite.
// Ports: Clock, async active-low Reset_n, and the slave side of a_b_and_alu_if.
module a_b_and_alu
    import a_b_and_alu_pkg::*;
#(
    parameter logic [WIDTH-1:0] CONST_A7 = CONST_A7_DEFAULT
) (
    input  logic           Clock,
    input  logic           Reset_n,
    a_b_and_alu_if.slave   bus
);

    logic [WIDTH-1:0] areg_q,        areg_d;
    logic [WIDTH-1:0] breg_q,        breg_d;
    logic [WIDTH-1:0] alu_out_reg_q, alu_out_reg_d;

    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_overflow;

    // A-mux
    always_comb begin
        alu_x = '0;
        case (asel_e'(bus.ALUAinput))
            ASEL_PC:    alu_x = bus.PC;
            ASEL_AREG:  alu_x = areg_q;
            ASEL_ZERO:  alu_x = '0;
            ASEL_READ1: alu_x = bus.Read1;
            ASEL_C:     alu_x = bus.C;
            ASEL_EXT:   alu_x = bus.ExType;
            ASEL_ONE:   alu_x = {{(WIDTH-1){1'b0}}, 1'b1};
            ASEL_CONST: alu_x = CONST_A7;
            default:    alu_x = '0;
        endcase
    end

    // B-mux
    always_comb begin
        alu_y = '0;
        case (bsel_e'(bus.ALUBinput))
            BSEL_BREG:  alu_y = breg_q;
            BSEL_EXT:   alu_y = bus.ExType;
            BSEL_SHIFT: alu_y = bus.Shifter;
            BSEL_ONE:   alu_y = {{(WIDTH-1){1'b0}}, 1'b1};
            default:    alu_y = '0;
        endcase
    end

    alu16 u_alu (
        .x        (alu_x),
        .y        (alu_y),
        .op       (bus.ALUOp),
        .result   (alu_result),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

    // Independent load enables; a disabled register holds its value.
    always_comb begin
        areg_d        = areg_q;
        breg_d        = breg_q;
        alu_out_reg_d = alu_out_reg_q;
        if (bus.AWrite)      areg_d        = bus.A;
        if (bus.BWrite)      breg_d        = bus.B;
        if (bus.ALUOutWrite) alu_out_reg_d = alu_result;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            areg_q        <= '0;
            breg_q        <= '0;
            alu_out_reg_q <= '0;
        end else begin
            areg_q        <= areg_d;
            breg_q        <= breg_d;
            alu_out_reg_q <= alu_out_reg_d;
        end
    end

    assign bus.ALUOut    = alu_result;
    assign bus.ALUOutReg = alu_out_reg_q;
    assign bus.Zero      = alu_zero;
    assign bus.OverFlow  = alu_overflow;

endmodule

// File: tb/tb_a_b_and_alu.sv
// Directed-vector bench for a_b_and_alu with hand-computed expected values.
// Inputs change away from the rising edge; outputs are sampled after settling.
// Prints one line per mismatch and a single summary line at the end.
module tb_a_b_and_alu;

    logic Clock;
    logic Reset_n;
    int   errors;
    int   checks;

    a_b_and_alu_if bus ();

    a_b_and_alu dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Set mux selects and op, then let the combinational path settle.
    task automatic setop(input logic [2:0] as, input logic [1:0] bs, input logic [2:0] op);
        bus.ALUAinput = as;
        bus.ALUBinput = bs;
        bus.ALUOp     = op;
        #1;
    endtask

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    // Observe Areg (X=Areg, Y=ExType=0, OR) and Breg (pass Y=Breg).
    task automatic chk_regs(input string tag, input logic [15:0] ea, input logic [15:0] eb);
        bus.ExType = 16'h0000;
        setop(3'd1, 2'd1, 3'd1);
        chk({tag, "_areg"}, bus.ALUOut, ea);
        setop(3'd0, 2'd0, 3'd7);
        chk({tag, "_breg"}, bus.ALUOut, eb);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0;
        checks = 0;
        Reset_n         = 1'b0;
        bus.PC          = '0;
        bus.A           = '0;
        bus.B           = '0;
        bus.Read1       = '0;
        bus.C           = '0;
        bus.ExType      = '0;
        bus.Shifter     = '0;
        bus.AWrite      = 1'b0;
        bus.BWrite      = 1'b0;
        bus.ALUOutWrite = 1'b0;
        bus.ALUAinput   = '0;
        bus.ALUBinput   = '0;
        bus.ALUOp       = '0;
        #12;
        chk("rst_aluoutreg", bus.ALUOutReg, 16'h0000);
        chk_regs("rst", 16'h0000, 16'h0000);
        Reset_n = 1'b1;
        #1;

        // Load A and B
        bus.A = 16'h1234; bus.B = 16'h5678;
        bus.AWrite = 1'b1; bus.BWrite = 1'b1;
        tick();
        bus.AWrite = 1'b0; bus.BWrite = 1'b0;

        bus.PC = 16'hc0de;
        setop(3'd0, 2'd0, 3'd0);
        chk("and_pc_breg", bus.ALUOut, 16'h4058);

        bus.ExType = 16'h0002;
        setop(3'd1, 2'd1, 3'd1);
        chk("or_areg_ext", bus.ALUOut, 16'h1236);
        chk("or_zero", 16'(bus.Zero), 16'h0000);

        bus.Read1 = 16'hb00b;
        setop(3'd3, 2'd0, 3'd3);
        chk("add_read1_breg", bus.ALUOut, 16'h0683);
        chk("add_ovf", 16'(bus.OverFlow), 16'h0000);
        chk("add_zero", 16'(bus.Zero), 16'h0000);

        bus.C = 16'h2357;
        setop(3'd4, 2'd1, 3'd4);
        chk("sub_c_ext", bus.ALUOut, 16'h2355);
        chk("sub_ovf", 16'(bus.OverFlow), 16'h0000);
        chk("sub_zero", 16'(bus.Zero), 16'h0000);

        bus.Shifter = 16'h2340;
        setop(3'd2, 2'd2, 3'd2);
        chk("nor_zero_shift", bus.ALUOut, 16'hdcbf);

        setop(3'd5, 2'd2, 3'd5);
        chk("slt_ext_shift", bus.ALUOut, 16'h0001);

        setop(3'd6, 2'd0, 3'd0);
        chk("and_one_breg", bus.ALUOut, 16'h0000);
        chk("and_one_zero", 16'(bus.Zero), 16'h0001);

        setop(3'd6, 2'd3, 3'd6);
        chk("xor_one_one", bus.ALUOut, 16'h0000);

        // ALUOutReg capture and hold
        setop(3'd7, 2'd1, 3'd1);
        chk("or_const_ext", bus.ALUOut, 16'h00f2);
        bus.ALUOutWrite = 1'b1;
        tick();
        chk("aluoutreg_load", bus.ALUOutReg, 16'h00f2);
        bus.ALUOutWrite = 1'b0;
        setop(3'd0, 2'd0, 3'd0);
        tick();
        chk("aluoutreg_hold", bus.ALUOutReg, 16'h00f2);

        // SUB boundary cases
        bus.Read1 = 16'h8234; bus.Shifter = 16'h8234;
        setop(3'd3, 2'd2, 3'd4);
        chk("sub_eq", bus.ALUOut, 16'h0000);
        chk("sub_eq_zero", 16'(bus.Zero), 16'h0001);
        chk("sub_eq_ovf", 16'(bus.OverFlow), 16'h0000);
        bus.Read1 = 16'h7234; bus.Shifter = 16'ha234;
        #1;
        chk("sub_ovf_res", bus.ALUOut, 16'hd000);
        chk("sub_ovf_flag", 16'(bus.OverFlow), 16'h0001);
        chk("sub_ovf_zero", 16'(bus.Zero), 16'h0000);
        // Overflow is suppressed for non-arithmetic ops on the same operands
        setop(3'd3, 2'd2, 3'd6);
        chk("xor_no_ovf", 16'(bus.OverFlow), 16'h0000);

        // ADD overflow and SLT across the signed boundary
        bus.ExType = 16'h7fff;
        setop(3'd5, 2'd3, 3'd3);
        chk("add_max_res", bus.ALUOut, 16'h8000);
        chk("add_max_ovf", 16'(bus.OverFlow), 16'h0001);
        bus.ExType = 16'h8000; bus.Shifter = 16'h7fff;
        setop(3'd5, 2'd2, 3'd5);
        chk("slt_neg_pos", bus.ALUOut, 16'h0001);
        bus.ExType = 16'h7fff; bus.Shifter = 16'h8000;
        #1;
        chk("slt_pos_neg", bus.ALUOut, 16'h0000);

        // Asynchronous reset between edges
        @(posedge Clock);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_aluoutreg", bus.ALUOutReg, 16'h0000);
        chk_regs("arst", 16'h0000, 16'h0000);
        Reset_n = 1'b1;
        bus.A = 16'hffff; bus.B = 16'haaaa;
        bus.AWrite = 1'b0; bus.BWrite = 1'b0;
        tick();
        chk("hold_aluoutreg", bus.ALUOutReg, 16'h0000);
        chk_regs("hold", 16'h0000, 16'h0000);

        // Enables are independent
        bus.AWrite = 1'b1;
        tick();
        bus.AWrite = 1'b0;
        chk_regs("awr_only", 16'hffff, 16'h0000);
        bus.BWrite = 1'b1;
        tick();
        bus.BWrite = 1'b0;
        chk_regs("bwr_only", 16'hffff, 16'haaaa);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
